// File: rtl/stack_alu_sequencer.sv
// Sequences pop/exec/push for one stack instruction at a time; the ALU stays a pure datapath.
// Latency: binary ops 5 cycles accept-to-accept, DROP/DUP 2, NOP 1; all outputs are registered-state Moore.
// Backpressure: instr_ready is high only in IDLE; a fault parks the block (ready low, pc held) until reset.
module stack_alu_sequencer #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic [3:0]            instr_op,
    output logic                  instr_ready,
    input  logic [DEPTH_BITS:0]   stack_count,
    input  logic [WIDTH-1:0]      stack_top,
    output logic                  stack_pop,
    output logic                  stack_push,
    output logic [WIDTH-1:0]      stack_wr_data,
    output logic [3:0]            alu_op,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_zero,
    output logic                  pc_hold,
    output logic                  zero_flag,
    output logic                  fault
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_DROP = 4'h1;
    localparam logic [3:0] OP_DUP  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;

    localparam logic [DEPTH_BITS:0] CAPACITY = {1'b1, {DEPTH_BITS{1'b0}}};
    localparam logic [DEPTH_BITS:0] ONE      = {{DEPTH_BITS{1'b0}}, 1'b1};
    localparam logic [DEPTH_BITS:0] TWO      = {{(DEPTH_BITS-1){1'b0}}, 2'b10};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP_B = 3'd1,
        ST_POP_A = 3'd2,
        ST_EXEC  = 3'd3,
        ST_PUSH  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    state_t             state, state_nxt;
    logic [3:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   res_reg;
    logic               zero_reg;

    logic               accept;
    logic               dup_ok;
    logic               dup_load;

    assign accept   = instr_valid && (state == ST_IDLE);
    assign dup_ok   = (stack_count >= ONE) && (stack_count < CAPACITY);
    assign dup_load = accept && (instr_op == OP_DUP) && dup_ok;

    // Operand checks happen once at accept so a failing instruction never strobes the stack.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (instr_op)
                        OP_NOP:  state_nxt = ST_IDLE;
                        OP_DROP: state_nxt = (stack_count >= ONE) ? ST_POP_B : ST_FAULT;
                        OP_DUP:  state_nxt = dup_ok ? ST_PUSH : ST_FAULT;
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                                 state_nxt = (stack_count >= TWO) ? ST_POP_B : ST_FAULT;
                        default: state_nxt = ST_FAULT;
                    endcase
                end
            end
            ST_POP_B: state_nxt = (op_reg == OP_DROP) ? ST_IDLE : ST_POP_A;
            ST_POP_A: state_nxt = ST_EXEC;
            ST_EXEC:  state_nxt = ST_PUSH;
            ST_PUSH:  state_nxt = ST_IDLE;
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // b is the first pop (old top), a the second, so SUB computes a-b.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_reg   <= 4'h0;
            a_reg    <= '0;
            b_reg    <= '0;
            res_reg  <= '0;
            zero_reg <= 1'b0;
        end else begin
            if (accept) begin
                op_reg <= instr_op;
            end
            if (state == ST_POP_B) begin
                b_reg <= stack_top;
            end
            if (state == ST_POP_A) begin
                a_reg <= stack_top;
            end
            if (dup_load) begin
                res_reg <= stack_top;
            end else if (state == ST_EXEC) begin
                res_reg <= alu_result;
            end
            if (state == ST_EXEC) begin
                zero_reg <= alu_zero;
            end
        end
    end

    always_comb begin
        instr_ready   = (state == ST_IDLE);
        pc_hold       = (state != ST_IDLE);
        stack_pop     = (state == ST_POP_B) || (state == ST_POP_A);
        stack_push    = (state == ST_PUSH);
        stack_wr_data = (state == ST_PUSH) ? res_reg : '0;
        alu_op        = (state == ST_EXEC) ? op_reg : 4'h0;
        alu_a         = a_reg;
        alu_b         = b_reg;
        zero_flag     = zero_reg;
        fault         = (state == ST_FAULT);
    end

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: stack and ALU environment, queue-based reference model,
// scoreboard of expected pushes drained by an independent monitor.
`timescale 1ns/1ps
module tb_stack_alu_sequencer;
    localparam int W   = 32;
    localparam int DB  = 4;
    localparam int CAP = 16;

    logic          clock;
    logic          reset;
    logic          instr_valid;
    logic [3:0]    instr_op;
    logic          instr_ready;
    logic [DB:0]   stack_count;
    logic [W-1:0]  stack_top;
    logic          stack_pop;
    logic          stack_push;
    logic [W-1:0]  stack_wr_data;
    logic [3:0]    alu_op;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [W-1:0]  alu_result;
    logic          alu_zero;
    logic          pc_hold;
    logic          zero_flag;
    logic          fault;

    int n_cmp;
    int n_bad;

    stack_alu_sequencer #(.WIDTH(W), .DEPTH_BITS(DB)) dut (
        .clock         (clock),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_op      (instr_op),
        .instr_ready   (instr_ready),
        .stack_count   (stack_count),
        .stack_top     (stack_top),
        .stack_pop     (stack_pop),
        .stack_push    (stack_push),
        .stack_wr_data (stack_wr_data),
        .alu_op        (alu_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .pc_hold       (pc_hold),
        .zero_flag     (zero_flag),
        .fault         (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Operand stack environment; the bench preloads it through ld_req.
    logic [W-1:0] mem    [CAP];
    logic [W-1:0] ld_mem [CAP];
    logic [DB:0]  env_cnt;
    logic [DB:0]  ld_cnt;
    logic         ld_req;

    always @(posedge clock) begin
        if (ld_req) begin
            for (int i = 0; i < CAP; i++) mem[i] <= ld_mem[i];
            env_cnt <= ld_cnt;
        end else if (stack_pop && env_cnt != 5'd0) begin
            env_cnt <= env_cnt - 5'd1;
        end else if (stack_push && env_cnt != 5'd16) begin
            mem[env_cnt[DB-1:0]] <= stack_wr_data;
            env_cnt <= env_cnt + 5'd1;
        end
    end

    assign stack_count = env_cnt;
    assign stack_top   = (env_cnt == 5'd0) ? '0 : mem[4'(env_cnt - 5'd1)];

    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'h3:    alu_result = alu_a + alu_b;
            4'h4:    alu_result = alu_a - alu_b;
            4'h5:    alu_result = alu_a & alu_b;
            4'h6:    alu_result = alu_a | alu_b;
            4'h7:    alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    // Reference model: back of ref_stk is the top of stack.
    logic [W-1:0] ref_stk[$];
    logic [W-1:0] exp_push_q[$];
    logic         ref_zero;
    logic         ref_fault;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Returns instruction class: 0 NOP, 1 DROP, 2 DUP, 3 binary, 4 fault.
    function automatic int model(input logic [3:0] op);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        int n;
        n = ref_stk.size();
        if (op == 4'h0) return 0;
        if (op == 4'h1) begin
            if (n >= 1) begin
                void'(ref_stk.pop_back());
                return 1;
            end
        end else if (op == 4'h2) begin
            if (n >= 1 && n < CAP) begin
                r = ref_stk[n-1];
                ref_stk.push_back(r);
                exp_push_q.push_back(r);
                return 2;
            end
        end else if (op >= 4'h3 && op <= 4'h7) begin
            if (n >= 2) begin
                b = ref_stk.pop_back();
                a = ref_stk.pop_back();
                case (op)
                    4'h3:    r = a + b;
                    4'h4:    r = a - b;
                    4'h5:    r = a & b;
                    4'h6:    r = a | b;
                    default: r = a ^ b;
                endcase
                exp_a    = a;
                exp_b    = b;
                ref_zero = (r == '0);
                ref_stk.push_back(r);
                exp_push_q.push_back(r);
                return 3;
            end
        end
        ref_fault = 1'b1;
        return 4;
    endfunction

    // Expected {ready, pc_hold, pop, push, fault, alu_op} for cycle k of an L-cycle instruction.
    function automatic logic [8:0] exp_vec(input int cls, input int k, input int len, input logic [3:0] op);
        logic       rdy;
        logic       pop;
        logic       psh;
        logic [3:0] ao;
        if (cls == 4) return 9'b0_1_0_0_1_0000;
        rdy = (k == len);
        pop = (cls == 3 && k <= 2) || (cls == 1 && k == 1);
        psh = (cls == 3 && k == 4) || (cls == 2 && k == 1);
        ao  = (cls == 3 && k == 3) ? op : 4'h0;
        return {rdy, ~rdy, pop, psh, 1'b0, ao};
    endfunction

    task automatic check_reset_vals(input string nm);
        chk({nm, "_ctl"}, 64'({instr_ready, stack_pop, stack_push, alu_op, pc_hold, zero_flag, fault}),
            64'(10'b1_0_0_0000_0_0_0));
        chk({nm, "_wdat"}, 64'(stack_wr_data), 64'd0);
        chk({nm, "_alu_a"}, 64'(alu_a), 64'd0);
        chk({nm, "_alu_b"}, 64'(alu_b), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        instr_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_vals("rst");
        ref_zero  = 1'b0;
        ref_fault = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic preload(input int n);
        ref_stk.delete();
        for (int i = 0; i < n; i++) ref_stk.push_back(ld_mem[i]);
        ld_cnt = 5'(n);
        ld_req = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ld_req = 1'b0;
    endtask

    // Starts and ends at a negedge with the sequencer idle (or faulted).
    task automatic run_instr(input logic [3:0] op, input bit hold_next, input logic [3:0] nxt_op,
                             input int abort_k);
        int cls;
        int len;
        chk("start_idle", 64'(instr_ready), 64'd1);
        if (instr_ready !== 1'b1) return;
        instr_valid = 1'b1;
        instr_op    = op;
        @(posedge clock);
        cls = model(op);
        len = (cls == 0) ? 1 : (cls == 3) ? 5 : (cls == 4) ? 3 : 2;
        for (int k = 1; k <= len; k++) begin
            @(negedge clock);
            if (k == 1) begin
                if (hold_next) instr_op = nxt_op;
                else instr_valid = 1'b0;
            end
            if (k == abort_k) begin
                reset = 1'b0;
                #1;
                check_reset_vals("abort");
                void'(exp_push_q.pop_back());
                void'(ref_stk.pop_back());
                ref_zero = 1'b0;
                @(negedge clock);
                reset = 1'b1;
                chk("abort_count", 64'(env_cnt), 64'(ref_stk.size()));
                return;
            end
            chk($sformatf("cycle op%0h k%0d", op, k),
                64'({instr_ready, pc_hold, stack_pop, stack_push, fault, alu_op}),
                64'(exp_vec(cls, k, len, op)));
            if (cls == 3 && k == 3) begin
                chk("alu_a", 64'(alu_a), 64'(exp_a));
                chk("alu_b", 64'(alu_b), 64'(exp_b));
            end
        end
        chk("count", 64'(env_cnt), 64'(ref_stk.size()));
        if (ref_stk.size() > 0) chk("top", 64'(stack_top), 64'(ref_stk[$]));
        chk("zero_flag", 64'(zero_flag), 64'(ref_zero));
        chk("fault", 64'(fault), 64'(ref_fault));
    endtask

    // Monitor: every push must match the oldest outstanding expected word.
    always @(negedge clock) begin
        if (reset && stack_push) begin
            if (exp_push_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL push_unexpected: got %0h expected no push", stack_wr_data);
            end else begin
                chk("push_data", 64'(stack_wr_data), 64'(exp_push_q.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] cur_op;
        logic [3:0] nxt_op;
        bit         held;
        bit         hold;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        instr_valid = 1'b0;
        instr_op = 4'h0;
        ld_req = 1'b0;
        ld_cnt = '0;
        ref_zero = 1'b0;
        ref_fault = 1'b0;
        for (int i = 0; i < CAP; i++) ld_mem[i] = '0;
        #1;
        check_reset_vals("por");
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // SUB 9-4 with full per-cycle timing.
        ld_mem[0] = 32'd9; ld_mem[1] = 32'd4;
        preload(2);
        run_instr(4'h4, 1'b0, 4'h0, 0);

        // ADD wrapping to zero sets zero_flag; NOP leaves it.
        ld_mem[0] = 32'hFFFF_FFFF; ld_mem[1] = 32'd1;
        preload(2);
        run_instr(4'h3, 1'b0, 4'h0, 0);
        run_instr(4'h0, 1'b0, 4'h0, 0);

        // Underflow: binary op with one word.
        ld_mem[0] = 32'd7;
        preload(1);
        run_instr(4'h3, 1'b0, 4'h0, 0);
        do_reset();

        // Overflow: DUP on a full stack.
        for (int i = 0; i < CAP; i++) ld_mem[i] = 32'(i + 100);
        preload(16);
        run_instr(4'h2, 1'b0, 4'h0, 0);
        do_reset();

        // DUP of a single word.
        ld_mem[0] = 32'h2A;
        preload(1);
        run_instr(4'h2, 1'b0, 4'h0, 0);

        // ADD with valid held and a NOP queued behind it, then an illegal opcode.
        ld_mem[0] = 32'd3; ld_mem[1] = 32'd5;
        preload(2);
        run_instr(4'h3, 1'b1, 4'h0, 0);
        run_instr(4'h0, 1'b0, 4'h0, 0);
        run_instr(4'hB, 1'b0, 4'h0, 0);
        do_reset();

        // Reset during EXEC: pops are lost, no push.
        ld_mem[0] = 32'd1; ld_mem[1] = 32'd6; ld_mem[2] = 32'd3;
        preload(3);
        run_instr(4'h5, 1'b0, 4'h0, 3);

        // Randomised instruction stream.
        held = 1'b0;
        cur_op = 4'h0;
        for (int it = 0; it < 300; it++) begin
            if (ref_fault) begin
                do_reset();
                held = 1'b0;
            end
            if (!held) begin
                if (it % 20 == 0 || ref_stk.size() == 0 && $urandom_range(0, 1) == 1) begin
                    for (int i = 0; i < CAP; i++)
                        ld_mem[i] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                    preload(int'($urandom_range(0, 16)));
                end
                cur_op = ($urandom_range(0, 99) < 4) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            end
            nxt_op = ($urandom_range(0, 99) < 4) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            hold = ($urandom_range(0, 2) == 0);
            run_instr(cur_op, hold, nxt_op, 0);
            held = hold;
            cur_op = nxt_op;
        end
        @(negedge clock);
        instr_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("push_queue_drained", 64'(exp_push_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stack_alu_sequencer.md
# stack_alu_sequencer

Control sequencer for the stack machine's ALU datapath. It accepts one stack instruction at a time from fetch/decode and pops the operands from the operand stack. It then drives the ALU, pushes the result, and holds the PC until the instruction retires. It owns all pop/push/hold sequencing, so the ALU is purely a datapath.

## Interface
- WIDTH, 32, data word width
- DEPTH_BITS, 4, log2 of stack capacity (capacity = 2**DEPTH_BITS = 16)

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instr_valid  in  1  decode presents an instruction
- instr_op  in  4  opcode, sampled when instr_valid & instr_ready
- instr_ready  out  1  sequencer can accept an instruction
- stack_count  in  DEPTH_BITS+1  current stack occupancy
- stack_top  in  WIDTH  top-of-stack word (combinational from stack)
- stack_pop  out  1  pop strobe, one word per cycle asserted
- stack_push  out  1  push strobe
- stack_wr_data  out  WIDTH  word to push
- alu_op  out  4  ALU operation; 4'h0 when not executing
- alu_a, alu_b  out  WIDTH  ALU operands (registered)
- alu_result  in  WIDTH  combinational ALU result
- alu_zero  in  1  combinational ALU zero flag
- pc_hold  out  1  stall PC/fetch
- zero_flag  out  1  registered zero of last binary op
- fault  out  1  stack underflow/overflow or illegal opcode; sticky

## Operation
- Opcodes:
  - 4'h0 NOP: net stack change 0.
  - 4'h1 DROP: pops 1.
  - 4'h2 DUP: pushes a copy of the top.
  - 4'h3 ADD, 4'h4 SUB (a-b), 4'h5 AND, 4'h6 OR, 4'h7 XOR: binary; pop 2, push 1.
  - 4'h8–4'hF: illegal.
- States: IDLE, POP_B, POP_A, EXEC, PUSH, FAULT. All outputs are Moore, decoded from state and registers.
- IDLE: instr_ready=1, pc_hold=0. When an instruction is accepted, the opcode is latched and:
  - NOP: stay IDLE.
  - Binary: requires stack_count>=2; go to POP_B.
  - DROP: requires stack_count>=1; go to POP_B.
  - DUP: requires 1<=stack_count<capacity; res_reg<=stack_top; go to PUSH.
  - Failed check or illegal opcode: go to FAULT. No pop or push occurs.
- POP_B: stack_pop=1, b_reg<=stack_top. Goes to POP_A for binary ops, IDLE for DROP.
- POP_A: stack_pop=1, a_reg<=stack_top; go to EXEC.
- EXEC: alu_op=latched opcode. res_reg<=alu_result, zero_flag<=alu_zero; go to PUSH.
- PUSH: stack_push=1, stack_wr_data=res_reg; go to IDLE.
- FAULT: fault=1, instr_ready=0, pc_hold=1, no strobes. Left only by reset.
- pc_hold = (state != IDLE). instr_ready = (state == IDLE).
- Operand order: the first pop is b (top), the second pop is a. SUB yields a-b modulo 2**WIDTH; wrap is not flagged.
- zero_flag changes only in EXEC. NOP, DUP and DROP leave it unchanged.
- Binary ops cannot overflow (net -1). DUP is the only overflow source.

## Timing
- Accept at edge T (instr_valid & instr_ready).
- Binary op:
  - stack_pop high in cycles T+1 and T+2.
  - alu_op valid in T+3.
  - stack_push high in T+4.
  - instr_ready high again in T+5; next accept possible at T+5. Throughput is 5 cycles per instruction.
- DROP: pop in T+1, ready in T+2.
- DUP: push in T+1, ready in T+2.
- NOP: ready stays high, 1 cycle per instruction.
- Fault entry: FAULT is entered in T+1, with no strobe in any cycle.
- Reset (reset=0) forces state to IDLE and all registers to 0 immediately, independent of clock. Reset values:
  - instr_ready=1.
  - stack_pop, stack_push, alu_op, pc_hold, zero_flag, fault, stack_wr_data, alu_a, alu_b = 0.
- Reset mid-instruction abandons it. Words already popped are lost and no push occurs.
- Stack contract: stack_top reflects the new top in the cycle after a pop. stack_count updates in the cycle after a strobe.

## Test plan
- Push 9 then 4 (count=2). Issue SUB at T -> pops at T+1/T+2, alu_a=9, alu_b=4, alu_op=4 at T+3, push 5 at T+4, zero_flag=0, count=1.
- Stack {0xFFFFFFFF, 1}. Issue ADD -> push 0x00000000, zero_flag=1. Then NOP -> zero_flag remains 1.
- count=1, issue ADD -> no pop, fault=1, instr_ready=0, pc_hold=1 from T+1 onward. Release reset -> fault=0, instr_ready=1.
- count=16, issue DUP -> fault, no push. Separately, count=1 with top 0x2A, issue DUP -> push 0x2A at T+1, count=2.
- ADD followed by NOP, instr_valid held high -> instr_ready low T+1..T+4, pc_hold high T+1..T+4, NOP accepted at T+5. Opcode 4'hB -> fault.
- Assert reset during EXEC -> all outputs take reset values in the same cycle, no push, stack count unchanged from after the pops.
